shift_arbiter: RTL and testbench

// - Shares one combinational barrel shifter (SLL/SRA/ROR) between two requesters, e.g. the execute stage and the bit-manip/debug unit.
// - Round-robin arbitration, valid/ready on request and response sides, registered operands and result.
// - Produces a zero flag per result. Fixed 2-cycle accept-to-response latency; one operation in flight.

---
 rtl/shift_pkg.sv | 17 +
 rtl/shift_core.sv | 39 +++
 rtl/shift_arbiter.sv | 161 ++++++++++++++++
 tb/tb_shift_arbiter.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
// Shared op encodings, FSM states and default sizes for the shift arbiter.
package shift_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_AMT_W = 4;

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRA = 2'b01;
    localparam logic [1:0] OP_ROR = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

endpackage

// File: rtl/shift_core.sv
// Combinational log-stage barrel shifter (SLL/SRA/ROR) with zero flag.
// Zero latency, no flow control; op 2'b11 behaves as ROR.
module shift_core
    import shift_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int AMT_W = DEF_AMT_W
) (
    input  logic [WIDTH-1:0] i_data,
    input  logic [AMT_W-1:0] i_amt,
    input  logic [1:0]       i_op,
    output logic [WIDTH-1:0] o_data,
    output logic             o_z
);

    logic [WIDTH-1:0] w_stage [AMT_W+1];

    assign w_stage[0] = i_data;

    // Stage k shifts by 2^k when amount bit k is set.
    for (genvar k = 0; k < AMT_W; k++) begin : g_stage
        localparam int SH = 1 << k;
        logic [WIDTH-1:0] w_shifted;

        always_comb begin
            case (i_op)
                OP_SLL:  w_shifted = w_stage[k] << SH;
                OP_SRA:  w_shifted = $unsigned($signed(w_stage[k]) >>> SH);
                default: w_shifted = (w_stage[k] >> SH) | (w_stage[k] << (WIDTH - SH));
            endcase
        end

        assign w_stage[k+1] = i_amt[k] ? w_shifted : w_stage[k];
    end

    assign o_data = w_stage[AMT_W];
    assign o_z    = (w_stage[AMT_W] == '0);

endmodule

// File: rtl/shift_arbiter.sv
// Round-robin share of one barrel shifter between two ports; accept->resp_valid 2 cycles, one op in flight.
// Response held until resp_ready; requests stall while busy. SHIFT_ARB_STATS_EN enables grant counters.
module shift_arbiter
    import shift_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int AMT_W = DEF_AMT_W,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_data,
    input  logic [AMT_W-1:0] req0_amt,
    input  logic [1:0]       req0_op,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_data,
    input  logic [AMT_W-1:0] req1_amt,
    input  logic [1:0]       req1_op,
    output logic             resp0_valid,
    input  logic             resp0_ready,
    output logic [WIDTH-1:0] resp0_data,
    output logic             resp0_z,
    output logic             resp1_valid,
    input  logic             resp1_ready,
    output logic [WIDTH-1:0] resp1_data,
    output logic             resp1_z,
    output logic [CNT_W-1:0] gnt_cnt0,
    output logic [CNT_W-1:0] gnt_cnt1
);

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_last_gnt;
    logic             r_id;
    logic [WIDTH-1:0] r_data;
    logic [AMT_W-1:0] r_amt;
    logic [1:0]       r_op;
    logic [WIDTH-1:0] r_res;
    logic             r_z;

    logic             w_any;
    logic             w_gnt_id;
    logic             w_accept;
    logic             w_resp_rdy;
    logic [WIDTH-1:0] w_core_data;
    logic             w_core_z;

    // On a tie the port that did not win last time is granted.
    assign w_any      = req0_valid | req1_valid;
    assign w_gnt_id   = req1_valid & (~req0_valid | ~r_last_gnt);
    assign w_accept   = (r_state == ST_IDLE) & w_any;
    assign w_resp_rdy = r_id ? resp1_ready : resp0_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        req0_ready  = 1'b0;
        req1_ready  = 1'b0;
        resp0_valid = 1'b0;
        resp1_valid = 1'b0;
        case (r_state)
            ST_IDLE: begin
                req0_ready = w_any & ~w_gnt_id;
                req1_ready = w_any &  w_gnt_id;
                if (w_any) begin
                    w_state_nxt = ST_EXEC;
                end
            end
            ST_EXEC: begin
                w_state_nxt = ST_RESP;
            end
            ST_RESP: begin
                resp0_valid = ~r_id;
                resp1_valid =  r_id;
                if (w_resp_rdy) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_gnt <= 1'b1;
            r_id       <= 1'b0;
            r_data     <= '0;
            r_amt      <= '0;
            r_op       <= OP_SLL;
            r_res      <= '0;
            r_z        <= 1'b0;
        end else begin
            if (w_accept) begin
                r_id       <= w_gnt_id;
                r_last_gnt <= w_gnt_id;
                r_data     <= w_gnt_id ? req1_data : req0_data;
                r_amt      <= w_gnt_id ? req1_amt  : req0_amt;
                r_op       <= w_gnt_id ? req1_op   : req0_op;
            end
            if (r_state == ST_EXEC) begin
                r_res <= w_core_data;
                r_z   <= w_core_z;
            end
        end
    end

    shift_core #(
        .WIDTH (WIDTH),
        .AMT_W (AMT_W)
    ) u_core (
        .i_data (r_data),
        .i_amt  (r_amt),
        .i_op   (r_op),
        .o_data (w_core_data),
        .o_z    (w_core_z)
    );

    // Only the owning port's valid is raised, so both ports can share the result register.
    assign resp0_data = r_res;
    assign resp1_data = r_res;
    assign resp0_z    = r_z;
    assign resp1_z    = r_z;

`ifdef SHIFT_ARB_STATS_EN
    logic [CNT_W-1:0] r_cnt0;
    logic [CNT_W-1:0] r_cnt1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt0 <= '0;
            r_cnt1 <= '0;
        end else begin
            if (w_accept && !w_gnt_id && (r_cnt0 != '1)) begin
                r_cnt0 <= r_cnt0 + CNT_W'(1);
            end
            if (w_accept && w_gnt_id && (r_cnt1 != '1)) begin
                r_cnt1 <= r_cnt1 + CNT_W'(1);
            end
        end
    end

    assign gnt_cnt0 = r_cnt0;
    assign gnt_cnt1 = r_cnt1;
`else
    assign gnt_cnt0 = '0;
    assign gnt_cnt1 = '0;
`endif

endmodule

// File: tb/tb_shift_arbiter.sv
// Directed bench for shift_arbiter: reset, arithmetic corners, round-robin, backpressure, reset abort, stats.
module tb_shift_arbiter;

    localparam int WIDTH = 16;
    localparam int AMT_W = 4;
    localparam int CNT_W = 2;

    localparam logic [1:0] SLL = 2'b00;
    localparam logic [1:0] SRA = 2'b01;
    localparam logic [1:0] ROR = 2'b10;

    logic             clk = 1'b0;
    logic             rst;
    logic             req0_valid, req1_valid;
    logic             req0_ready, req1_ready;
    logic [WIDTH-1:0] req0_data, req1_data;
    logic [AMT_W-1:0] req0_amt, req1_amt;
    logic [1:0]       req0_op, req1_op;
    logic             resp0_valid, resp1_valid;
    logic             resp0_ready, resp1_ready;
    logic [WIDTH-1:0] resp0_data, resp1_data;
    logic             resp0_z, resp1_z;
    logic [CNT_W-1:0] gnt_cnt0, gnt_cnt1;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    shift_arbiter #(
        .WIDTH (WIDTH),
        .AMT_W (AMT_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req0_valid  (req0_valid),
        .req0_ready  (req0_ready),
        .req0_data   (req0_data),
        .req0_amt    (req0_amt),
        .req0_op     (req0_op),
        .req1_valid  (req1_valid),
        .req1_ready  (req1_ready),
        .req1_data   (req1_data),
        .req1_amt    (req1_amt),
        .req1_op     (req1_op),
        .resp0_valid (resp0_valid),
        .resp0_ready (resp0_ready),
        .resp0_data  (resp0_data),
        .resp0_z     (resp0_z),
        .resp1_valid (resp1_valid),
        .resp1_ready (resp1_ready),
        .resp1_data  (resp1_data),
        .resp1_z     (resp1_z),
        .gnt_cnt0    (gnt_cnt0),
        .gnt_cnt1    (gnt_cnt1)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // One uncontended op on port p with resp_ready already high.
    task automatic run_op(input string tag, input bit p, input logic [15:0] d,
                          input logic [3:0] a, input logic [1:0] o,
                          input logic [15:0] exp_d, input bit exp_z);
        if (p == 1'b0) begin
            req0_valid = 1'b1; req0_data = d; req0_amt = a; req0_op = o;
        end else begin
            req1_valid = 1'b1; req1_data = d; req1_amt = a; req1_op = o;
        end
        #1;
        chk({tag, ".rdy"}, p ? req1_ready : req0_ready, 1'b1);
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        chk({tag, ".exec_vld"}, {resp1_valid, resp0_valid}, 2'b00);
        tick();
        chk({tag, ".vld"}, {resp1_valid, resp0_valid}, p ? 2'b10 : 2'b01);
        chk({tag, ".dat"}, p ? resp1_data : resp0_data, exp_d);
        chk({tag, ".z"}, p ? resp1_z : resp0_z, exp_z);
        tick();
        chk({tag, ".done"}, {resp1_valid, resp0_valid}, 2'b00);
    endtask

    logic [15:0] d0, d1, exp_d;
    bit          exp_p;

    initial begin
        rst = 1'b1;
        req0_valid = 1'b0; req0_data = '0; req0_amt = '0; req0_op = SLL;
        req1_valid = 1'b0; req1_data = '0; req1_amt = '0; req1_op = SLL;
        resp0_ready = 1'b1; resp1_ready = 1'b1;

        // Reset state
        tick();
        tick();
        chk("rst.ready", {req1_ready, req0_ready}, 2'b00);
        chk("rst.valid", {resp1_valid, resp0_valid}, 2'b00);
        chk("rst.data", resp0_data, 16'h0000);
        chk("rst.z", {resp1_z, resp0_z}, 2'b00);
        chk("rst.cnt", {gnt_cnt1, gnt_cnt0}, 4'h0);
        rst = 1'b0;

        // Single op and arithmetic corners
        run_op("ror1",    1'b0, 16'h8001, 4'd1,  ROR,   16'hC000, 1'b0);
        run_op("sra15",   1'b1, 16'h8000, 4'd15, SRA,   16'hFFFF, 1'b0);
        run_op("sll0",    1'b0, 16'h0001, 4'd0,  SLL,   16'h0001, 1'b0);
        run_op("sll1z",   1'b1, 16'h8000, 4'd1,  SLL,   16'h0000, 1'b1);
        run_op("sra4pos", 1'b0, 16'h7FFF, 4'd4,  SRA,   16'h07FF, 1'b0);
        run_op("ror4",    1'b1, 16'h1234, 4'd4,  ROR,   16'h4123, 1'b0);
        run_op("ror11op", 1'b0, 16'h000F, 4'd8,  2'b11, 16'h0F00, 1'b0);
        run_op("sll4",    1'b1, 16'h0F0F, 4'd4,  SLL,   16'hF0F0, 1'b0);
        run_op("ror0",    1'b0, 16'hA5A5, 4'd0,  ROR,   16'hA5A5, 1'b0);

        // Contention from a fresh reset: grants must alternate starting with port 0
        do_reset();
        d0 = 16'hA000; d1 = 16'hB000;
        req0_valid = 1'b1; req0_amt = 4'd0; req0_op = SLL; req0_data = d0;
        req1_valid = 1'b1; req1_amt = 4'd0; req1_op = SLL; req1_data = d1;
        for (int i = 0; i < 6; i++) begin
            exp_p = (i % 2 == 1);
            exp_d = exp_p ? d1 : d0;
            #1;
            chk($sformatf("rr%0d.rdy", i), {req1_ready, req0_ready}, exp_p ? 2'b10 : 2'b01);
            tick();
            chk($sformatf("rr%0d.exec_rdy", i), {req1_ready, req0_ready}, 2'b00);
            tick();
            chk($sformatf("rr%0d.vld", i), {resp1_valid, resp0_valid}, exp_p ? 2'b10 : 2'b01);
            chk($sformatf("rr%0d.dat", i), exp_p ? resp1_data : resp0_data, exp_d);
            tick();
            if (exp_p) begin d1 = d1 + 16'h1; req1_data = d1; end
            else begin d0 = d0 + 16'h1; req0_data = d0; end
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        tick();

        // Backpressure on port 1 while port 0 waits
        resp1_ready = 1'b0;
        req1_valid = 1'b1; req1_data = 16'h00F0; req1_amt = 4'd4; req1_op = SRA;
        #1;
        chk("bp.rdy1", req1_ready, 1'b1);
        tick();
        req1_valid = 1'b0;
        req0_valid = 1'b1; req0_data = 16'h0003; req0_amt = 4'd2; req0_op = SLL;
        tick();
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("bp%0d.vld", i), {resp1_valid, resp0_valid}, 2'b10);
            chk($sformatf("bp%0d.dat", i), resp1_data, 16'h000F);
            chk($sformatf("bp%0d.rdy0", i), req0_ready, 1'b0);
            tick();
        end
        resp1_ready = 1'b1;
        chk("bp.last_vld", resp1_valid, 1'b1);
        tick();
        chk("bp.release", {resp1_valid, resp0_valid}, 2'b00);
        chk("bp.rdy0", req0_ready, 1'b1);
        tick();
        req0_valid = 1'b0;
        tick();
        chk("bp.r0vld", resp0_valid, 1'b1);
        chk("bp.r0dat", resp0_data, 16'h000C);
        tick();

        // Reset while EXEC: no response, back to IDLE, tie goes to port 0 again
        req1_valid = 1'b1; req1_data = 16'h1111; req1_amt = 4'd1; req1_op = SLL;
        tick();
        req1_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("rstx%0d.vld", i), {resp1_valid, resp0_valid}, 2'b00);
            tick();
        end
        req0_valid = 1'b1; req0_data = 16'h0001; req0_amt = 4'd0; req0_op = SLL;
        req1_valid = 1'b1; req1_data = 16'h0002; req1_amt = 4'd0; req1_op = SLL;
        #1;
        chk("rstx.tie", {req1_ready, req0_ready}, 2'b01);
        req0_valid = 1'b0; req1_valid = 1'b0;
        #1;

        // Grant counters: CNT_W=2 saturates at 3
        do_reset();
        for (int i = 0; i < 5; i++) begin
            run_op($sformatf("cnt%0d", i), 1'b0, 16'h0010, 4'd1, SLL, 16'h0020, 1'b0);
`ifdef SHIFT_ARB_STATS_EN
            chk($sformatf("cnt%0d.val", i), gnt_cnt0, (i < 3) ? (i + 1) : 3);
`else
            chk($sformatf("cnt%0d.val", i), gnt_cnt0, 0);
`endif
        end
        chk("cnt.port1", gnt_cnt1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
